// File: rtl/pixel_pkg.sv
// Shared pixel/word geometry for the convolution pipeline (line_buffer and pixel_packer).
package pixel_pkg;

    localparam int PIXEL_WIDTH     = 8;
    localparam int PIXELS_PER_WORD = 4;
    localparam int LANE_WIDTH      = $clog2(PIXELS_PER_WORD);

    typedef logic [LANE_WIDTH-1:0]  lane_t;
    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    localparam lane_t LAST_LANE = lane_t'(PIXELS_PER_WORD - 1);

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with pointer-derived count; the head reads as zero when empty.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pixel_packer.sv
// Packs accepted 8-bit pixels LSB-first into 32-bit words behind a small FWFT FIFO.
// Define PIXEL_PACKER_LAST_EN to track rows and flag the final word of each frame.
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 324,
    parameter int IMAGE_HEIGHT = 324,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_pixel,
    input  logic                  i_pixel_valid,
    output logic                  o_pixel_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_data_last
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    lane_t                                      lane;
    logic [PIXELS_PER_WORD-2:0][PIXEL_WIDTH-1:0] holding;
    logic [COL_W-1:0]                           col;
    logic                                       col_last;
    logic                                       accept;
    logic                                       push;
    logic                                       pop;
    logic                                       fifo_full;
    logic                                       fifo_empty;
    logic [DATA_WIDTH-1:0]                      packed_word;

    // Only a completing pixel needs FIFO space, so partial lanes keep flowing when full.
    assign o_pixel_ready = !((lane == LAST_LANE) && fifo_full);
    assign accept        = i_pixel_valid && o_pixel_ready;
    assign push          = accept && (lane == LAST_LANE);
    assign pop           = o_data_valid && i_data_ready;
    assign o_data_valid  = !fifo_empty;
    assign packed_word   = {i_pixel, holding};
    assign col_last      = (col == COL_W'(IMAGE_WIDTH - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lane    <= '0;
            holding <= '0;
            col     <= '0;
        end else if (accept) begin
            lane <= lane + 1'b1;
            for (int k = 0; k < PIXELS_PER_WORD - 1; k++) begin
                if (lane == lane_t'(k)) holding[k] <= i_pixel;
            end
            col <= col_last ? '0 : col + 1'b1;
        end
    end

`ifdef PIXEL_PACKER_LAST_EN
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [ROW_W-1:0]    row;
    logic                frame_last;
    logic [DATA_WIDTH:0] fifo_head;

    assign frame_last = col_last && (row == ROW_W'(IMAGE_HEIGHT - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            row <= '0;
        end else if (accept && col_last) begin
            row <= frame_last ? '0 : row + 1'b1;
        end
    end

    word_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  ({frame_last, packed_word}),
        .i_pop   (pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_data      = fifo_head[DATA_WIDTH-1:0];
    assign o_data_last = fifo_head[DATA_WIDTH];
`else
    word_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (packed_word),
        .i_pop   (pop),
        .o_data  (o_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_data_last = 1'b0;
`endif

endmodule
